// File: rtl/mux_2to1_8b_pkg.sv
// Shared CPU datapath constants.
// Supplies the byte width used by the operand-select muxes.
package mux_2to1_8b_pkg;

    localparam int DATA_WIDTH = 8;

endpackage

// File: rtl/mux_2to1_bit.sv
// One-bit 2:1 select cell.
// The ternary keeps agreeing bits defined when select is unknown.
module mux_2to1_bit (
    input  logic data_a,
    input  logic data_b,
    input  logic select,
    output logic result
);

    assign result = select ? data_b : data_a;

endmodule

// File: rtl/mux_2to1_8b.sv
// Byte-wide 2:1 operand mux for the CPU datapath.
// Provides a combinational result and a reset-defined registered copy.
module mux_2to1_8b
    import mux_2to1_8b_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic [WIDTH-1:0] input_a,
    input  logic [WIDTH-1:0] input_b,
    input  logic             input_select,
    output logic [WIDTH-1:0] output_result,
    output logic [WIDTH-1:0] output_result_q,
    input  logic             clk,
    input  logic             rst
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        mux_2to1_bit u_bit (
            .data_a (input_a[i]),
            .data_b (input_b[i]),
            .select (input_select),
            .result (output_result[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            output_result_q <= '0;
        end else begin
            output_result_q <= output_result;
        end
    end

endmodule

// File: tb/tb_mux_2to1_8b.sv
// Bench for mux_2to1_8b: vector table, hand sequences, random run.
// Expected values come from an operand-array pick and a one-deep delay model.
module tb_mux_2to1_8b;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sel;
        logic [7:0] exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a;
    logic [7:0] b;
    logic       sel;
    logic [7:0] y;
    logic [7:0] yq;
    logic [7:0] q_ref;
    int         total = 0;
    int         bad = 0;
    vec_t       vecs[8];

    always #5 clk = ~clk;

    mux_2to1_8b #(.WIDTH(8)) dut (
        .input_a         (a),
        .input_b         (b),
        .input_select    (sel),
        .output_result   (y),
        .output_result_q (yq),
        .clk             (clk),
        .rst             (rst)
    );

    function automatic logic [7:0] pick(logic [7:0] va, logic [7:0] vb, logic vs);
        logic [7:0] ops[2];
        ops[0] = va;
        ops[1] = vb;
        return ops[vs];
    endfunction

    task automatic check(string name, logic [7:0] act, logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply inputs mid-cycle, check comb output, then the register after the edge.
    task automatic drive(logic r, logic [7:0] va, logic [7:0] vb, logic vs);
        @(negedge clk);
        rst = r;
        a   = va;
        b   = vb;
        sel = vs;
        #1;
        check("comb", y, pick(va, vb, vs));
        @(posedge clk);
        q_ref = r ? 8'h00 : pick(va, vb, vs);
        #1;
        check("reg", yq, q_ref);
    endtask

    initial begin
        vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00};
        vecs[1] = '{8'hFF, 8'h00, 1'b0, 8'hFF};
        vecs[2] = '{8'h00, 8'hFF, 1'b0, 8'h00};
        vecs[3] = '{8'hFF, 8'hFF, 1'b0, 8'hFF};
        vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h00};
        vecs[5] = '{8'hFF, 8'h00, 1'b1, 8'h00};
        vecs[6] = '{8'h00, 8'hFF, 1'b1, 8'hFF};
        vecs[7] = '{8'hFF, 8'hFF, 1'b1, 8'hFF};

        // Reset edge with a=FF selected.
        rst = 1'b1;
        a   = 8'hFF;
        b   = 8'h00;
        sel = 1'b0;
        #1;
        check("reset_comb", y, 8'hFF);
        @(posedge clk);
        #1;
        check("reset_q", yq, 8'h00);
        check("reset_comb_after", y, 8'hFF);
        q_ref = 8'h00;

        for (int i = 0; i < 8; i++) begin
            drive(1'b0, vecs[i].a, vecs[i].b, vecs[i].sel);
            check("table", y, vecs[i].exp);
        end

        // Select toggling every cycle.
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 8'hA5, 8'h5A, i[0]);
            check("toggle_comb", y, i[0] ? 8'h5A : 8'hA5);
            check("toggle_q", yq, i[0] ? 8'h5A : 8'hA5);
        end

        // Mid-stream reset and release.
        drive(1'b0, 8'hA5, 8'h5A, 1'b1);
        check("pre_rst_q", yq, 8'h5A);
        drive(1'b1, 8'hA5, 8'h5A, 1'b0);
        check("rst_q", yq, 8'h00);
        check("rst_comb", y, 8'hA5);
        drive(1'b1, 8'h3C, 8'hC3, 1'b1);
        check("rst_comb2", y, 8'hC3);
        drive(1'b0, 8'h3C, 8'hC3, 1'b1);
        check("release_q", yq, 8'hC3);

        for (int i = 0; i < 1000; i++) begin
            drive(($urandom_range(0, 15) == 0), 8'($urandom), 8'($urandom),
                  1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
